// File: rtl/l0_pool_rd.sv
// Layer-0 2x2 max-pool reader: walks the 26x26 map in 2x2 windows and
// streams one signed maximum per window over a valid/ready port.
module l0_pool_rd #(
  parameter int DW    = 18,
  parameter int MAP_W = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd,
  output logic [9:0]           addr_rd,
  input  logic [3:0][DW-1:0]   din,
  output logic                 pool_vld,
  input  logic                 pool_rdy,
  output logic [DW-1:0]        pool_data,
  output logic [7:0]           pool_idx
);

  localparam int PW = MAP_W / 2;
  localparam logic [9:0] A0 = 10'(MAP_W + 1);
  localparam logic [9:0] COL_STEP = 10'd2;
  localparam logic [9:0] ROW_STEP = 10'(2 * MAP_W - 2 * (PW - 1));
  localparam logic [3:0] LAST = 4'(PW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [3:0] r, c;
  logic [7:0] idx_cnt;
  logic capture, last_win, xfer;

  logic signed [DW-1:0] m01, m23, mx;

  assign capture  = (state == RUN) && (!pool_vld || pool_rdy);
  assign last_win = (r == LAST) && (c == LAST);
  assign xfer     = pool_vld && pool_rdy;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (capture && last_win) state_n = DRAIN;
      DRAIN:   if (xfer) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    rd   = capture;
    done = (state == DRAIN) && xfer;
  end

  // Two-level signed compare tree; ties keep either equal operand.
  always_comb begin
    m01 = ($signed(din[0]) > $signed(din[1])) ? $signed(din[0])
                                               : $signed(din[1]);
    m23 = ($signed(din[2]) > $signed(din[3])) ? $signed(din[2])
                                               : $signed(din[3]);
    mx  = (m01 > m23) ? m01 : m23;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_rd   <= A0;
      r         <= '0;
      c         <= '0;
      idx_cnt   <= '0;
      pool_vld  <= 1'b0;
      pool_data <= '0;
      pool_idx  <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr_rd <= A0;
        r       <= '0;
        c       <= '0;
        idx_cnt <= '0;
      end else if (capture) begin
        pool_data <= mx;
        pool_idx  <= idx_cnt;
        // Counters park on the final window until the next pass starts.
        if (!last_win) begin
          idx_cnt <= idx_cnt + 8'd1;
          if (c == LAST) begin
            c       <= '0;
            r       <= r + 4'd1;
            addr_rd <= addr_rd + ROW_STEP;
          end else begin
            c       <= c + 4'd1;
            addr_rd <= addr_rd + COL_STEP;
          end
        end
      end
      if (capture)
        pool_vld <= 1'b1;
      else if (xfer)
        pool_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l0_pool_rd.sv
// Self-checking bench for l0_pool_rd: signed-max vector table plus
// full-pass, stall, random-ready, restart and mid-pass reset sequences.
module tb_l0_pool_rd;

  localparam int DW = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, rd;
  logic [9:0]        addr_rd;
  logic [3:0][DW-1:0] din;
  logic              pool_vld;
  logic              pool_rdy;
  logic [DW-1:0]     pool_data;
  logic [7:0]        pool_idx;

  logic               ovr_en;
  logic [3:0][DW-1:0] ovr_d;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_idx, exp_rd, done_cnt, t0, t1;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l0_pool_rd #(.DW(DW), .MAP_W(26)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .rd(rd),
    .addr_rd(addr_rd),
    .din(din),
    .pool_vld(pool_vld),
    .pool_rdy(pool_rdy),
    .pool_data(pool_data),
    .pool_idx(pool_idx)
  );

  // RAM model holding value = address, or a forced window for the table.
  always_comb begin
    din = '0;
    if (ovr_en) begin
      din = ovr_d;
    end else begin
      din[0] = 18'(addr_rd) - 18'd27;
      din[1] = 18'(addr_rd) - 18'd26;
      din[2] = 18'(addr_rd) - 18'd1;
      din[3] = 18'(addr_rd);
    end
  end

  function automatic logic [31:0] exp_addr(input int i);
    return 32'(52 * (i / 13) + 2 * (i % 13) + 27);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd) begin
        chk("rd_addr", 32'(addr_rd), exp_addr(exp_rd));
        exp_rd++;
      end
      if (pool_vld && !pool_rdy)
        chk("stall_rd", 32'(rd), 32'd0);
      if (pool_vld && pool_rdy) begin
        chk("xfer_idx", 32'(pool_idx), 32'(exp_idx));
        chk("xfer_data", 32'(pool_data), exp_addr(exp_idx));
        chk("xfer_done", 32'(done), 32'(exp_idx == 168));
        if (done) done_cnt++;
        if (exp_idx == 0) t0 = cyc;
        if (exp_idx == 168) t1 = cyc;
        exp_idx++;
      end else if (done) begin
        chk("done_no_xfer", 32'(done), 32'd0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_pass(input int mode);
    int cnt;
    bit fired, abort;
    ovr_en = 1'b0;
    exp_idx = 0;
    exp_rd = 0;
    done_cnt = 0;
    fired = 1'b0;
    abort = 1'b0;
    cnt = 0;
    pool_rdy = 1'b1;
    mon_en = 1'b1;
    pulse_start();
    if (mode == 0) begin
      chk("lat_rd", 32'(rd), 32'd1);
      chk("lat_addr", 32'(addr_rd), 32'd27);
      @(posedge clk);
      #1;
      chk("lat_vld", 32'(pool_vld), 32'd1);
      chk("lat_idx", 32'(pool_idx), 32'd0);
    end
    while (exp_idx < 169 && cnt < 4000 && !abort) begin
      @(posedge clk);
      #1;
      cnt++;
      start = 1'b0;
      if (mode == 1) pool_rdy = 1'($urandom_range(0, 1));
      if (mode == 2 && !fired && pool_vld && pool_idx == 8'd40) begin
        fired = 1'b1;
        pool_rdy = 1'b0;
        repeat (10) begin
          @(posedge clk);
          #1;
          chk("stall_idx", 32'(pool_idx), 32'd40);
          chk("stall_data", 32'(pool_data), 32'd185);
          chk("stall_addr", 32'(addr_rd), 32'd187);
          chk("stall_rd0", 32'(rd), 32'd0);
        end
        pool_rdy = 1'b1;
      end
      if (mode == 3 && !fired && pool_vld && pool_idx == 8'd80) begin
        fired = 1'b1;
        start = 1'b1;
      end
      if (mode == 4 && pool_vld && pool_idx == 8'd100) begin
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        mon_en = 1'b0;
        abort = 1'b1;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_rd", 32'(rd), 32'd0);
        chk("ab_addr", 32'(addr_rd), 32'd27);
        chk("ab_vld", 32'(pool_vld), 32'd0);
        chk("ab_data", 32'(pool_data), 32'd0);
        chk("ab_idx", 32'(pool_idx), 32'd0);
      end
    end
    if (abort) begin
      repeat (3) @(posedge clk);
      #1;
      chk("ab_vld_late", 32'(pool_vld), 32'd0);
      chk("ab_busy_late", 32'(busy), 32'd0);
      chk("ab_no_done", 32'(done_cnt), 32'd0);
    end else begin
      chk("pass_len", 32'(exp_idx), 32'd169);
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
      chk("vld_after", 32'(pool_vld), 32'd0);
      chk("rd_total", 32'(exp_rd), 32'd169);
      if (mode == 0) chk("b2b_cycles", 32'(t1 - t0), 32'd168);
      if (mode == 3) begin
        repeat (5) @(posedge clk);
        #1;
        chk("no_restart", 32'(busy), 32'd0);
      end
    end
    mon_en = 1'b0;
  endtask

  typedef struct {
    string         name;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [DW-1:0] want;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pool_rdy = 1'b0;
    ovr_en = 1'b0;
    ovr_d = '0;

    vt[0] = '{"all_neg", 18'h3FFFB, 18'h3FFFD, 18'h20000, 18'h3FFFF,
              18'h3FFFF};
    vt[1] = '{"mixed", 18'h1FFFF, 18'h20000, 18'h00000, 18'h00005,
              18'h1FFFF};
    vt[2] = '{"tie_pos", 18'h00007, 18'h00007, 18'h00007, 18'h00007,
              18'h00007};
    vt[3] = '{"tie_min", 18'h20000, 18'h20000, 18'h20000, 18'h20000,
              18'h20000};
    vt[4] = '{"slot2", 18'h00010, 18'h3FFF0, 18'h00011, 18'h00002,
              18'h00011};
    vt[5] = '{"slot0", 18'h1FFFF, 18'h1FFFE, 18'h3FFFF, 18'h00000,
              18'h1FFFF};
    vt[6] = '{"slot3", 18'h00000, 18'h3FFFF, 18'h00001, 18'h00002,
              18'h00002};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_addr", 32'(addr_rd), 32'd27);
    chk("rst_vld", 32'(pool_vld), 32'd0);
    chk("rst_data", 32'(pool_data), 32'd0);
    chk("rst_idx", 32'(pool_idx), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      ovr_en = 1'b1;
      ovr_d[0] = vt[i].d0;
      ovr_d[1] = vt[i].d1;
      ovr_d[2] = vt[i].d2;
      ovr_d[3] = vt[i].d3;
      pool_rdy = 1'b0;
      pulse_start();
      @(posedge clk);
      #1;
      chk({"max_", vt[i].name}, 32'(pool_data), 32'(vt[i].want));
      chk({"vld_", vt[i].name}, 32'(pool_vld), 32'd1);
    end
    ovr_en = 1'b0;
    do_reset();

    run_pass(0);
    run_pass(2);
    run_pass(1);
    run_pass(3);
    run_pass(4);
    run_pass(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l0_pool_rd.md
L0_POOL_RD -- requirements
Module: l0_pool_rd

Interface
REQ-001 Parameter DW, default 18: data width of the layer-0 feature map and of the pooled output.
REQ-002 Parameter MAP_W, default 26: feature-map edge length; the pooled map is MAP_W/2 = 13 per side, 169 windows.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to pool one full map; sampled only in IDLE.
REQ-006 busy  output  1  high in RUN and DRAIN.
REQ-007 done  output  1  one-cycle pulse when the last pooled value has been accepted.
REQ-008 rd  output  1  read enable to the layer-0 RAM.
REQ-009 addr_rd  output  10  bottom-right address of the current 2x2 window.
REQ-010 din  input  DW x4  window data from the RAM: [0]=addr-27, [1]=addr-26, [2]=addr-1, [3]=addr; valid combinationally in the cycle rd/addr_rd are driven.
REQ-011 pool_vld  output  1  pooled result valid.
REQ-012 pool_rdy  input  1  downstream accepts; transfer = pool_vld & pool_rdy.
REQ-013 pool_data  output  DW  signed maximum of the four window values.
REQ-014 pool_idx  output  8  pooled index 13*r + c, 0..168.

Function
REQ-015 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when the window at (12,12) is captured; DRAIN->IDLE when that result transfers, with done asserted in that transfer cycle.
REQ-016 Window (r,c) SHALL use addr_rd = 52r + 2c + 27: first 27, last 675; +2 within a row, +28 when c wraps 12->0.
REQ-017 Windows SHALL be issued row-major, r and c in 0..12, each exactly once, no skips or repeats.
REQ-018 rd SHALL be high only in RUN cycles where a window is captured; otherwise rd=0 and addr_rd holds.
REQ-019 Capture occurs when state=RUN and (pool_vld=0 or pool_rdy=1); then pool_data <= signed max(din[0..3]), pool_idx <= window index, pool_vld <= 1, and the window counters advance.
REQ-020 Comparison SHALL be two's-complement signed on DW bits; ties return the equal value, no saturation or width change.
REQ-021 Latency: start at edge N -> rd=1, addr_rd=27 in cycle N+1 -> pool_vld=1, pool_idx=0 in cycle N+2.
REQ-022 With pool_rdy held high, throughput is one window per cycle; 169 results in 169 consecutive cycles; done high in the cycle the index-168 result transfers.
REQ-023 When pool_vld=1 and pool_rdy=0, pool_data, pool_idx, addr_rd SHALL hold and rd=0.
REQ-024 pool_vld SHALL drop to 0 after a transfer when no new capture occurs in that cycle.
REQ-025 start while busy SHALL be ignored; it does not restart or queue a pass.
REQ-026 start in the cycle done pulses is ignored; a new start SHALL be accepted from the next IDLE cycle.

Reset
REQ-027 On rst: state=IDLE, busy=0, done=0, rd=0, addr_rd=27, pool_vld=0, pool_data=0, pool_idx=0, counters r=c=0.
REQ-028 rst asserted mid-pass SHALL abort immediately with no done pulse and no further pool_vld; rst dominates start in the same cycle.

Verification
REQ-029 RAM loaded with value=address, pool_rdy=1, start pulse -> 169 results, pool_idx 0..168 contiguous, pool_data = 52r+2c+27, done once with idx 168, busy low next cycle.
REQ-030 Window (0,0) din = {-5, -3, -131072, -1} (0x3FFFB, 0x3FFFD, 0x20000, 0x3FFFF) -> pool_data = 0x3FFFF (-1); mixed {0x1FFFF, 0x20000, 0, 5} -> 0x1FFFF.
REQ-031 pool_rdy low for 10 cycles at idx 40 -> pool_data/pool_idx/addr_rd stable, rd=0 during stall; resume with idx 41 next, no loss or duplicate.
REQ-032 Random pool_rdy at 50% -> result sequence identical to REQ-029; done exactly once.
REQ-033 start pulsed again at idx 80 -> ignored, single pass of 169 results.
REQ-034 rst asserted at idx 100 -> next cycle all outputs at reset values, no done; following start produces a full pass from idx 0.
